// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_arb_pkg : state encoding and constants shared by the SPI arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package spi_arb_pkg;

   localparam int SPI_CMD_W = 16;
   localparam logic [SPI_CMD_W-1:0] TO_RSP = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      GAP    = 2'd3
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_arb_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin priority encoder, search starts above i_rr_ptr
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_pend,
   input  logic [IDX_W-1:0]   i_rr_ptr,
   output logic               o_any,
   output logic [IDX_W-1:0]   o_winner
);

   logic [IDX_W:0] w_sum;

   // Walk from the farthest candidate to the nearest so the nearest hit wins.
   always_comb begin
      o_any    = 1'b0;
      o_winner = '0;
      w_sum    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_sum = {1'b0, i_rr_ptr} + (IDX_W + 1)'(k);
         if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
         end
         if (i_pend[w_sum[IDX_W-1:0]]) begin
            o_any    = 1'b1;
            o_winner = w_sum[IDX_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_arb : shares one 16-bit SPI master among NUM_REQ requesters
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int GAP_CYC = 4,
   parameter int TO_CYC  = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [SPI_CMD_W*NUM_REQ-1:0]   cmd_in,
   output logic [NUM_REQ-1:0]             req_done,
   output logic [SPI_CMD_W-1:0]           rsp_data,
   output logic                           busy,
   output logic                           err_to,
   output logic                           spi_wrt,
   output logic [SPI_CMD_W-1:0]           spi_cmd,
   input  logic                           spi_done,
   input  logic [SPI_CMD_W-1:0]           spi_rd_data
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TO_W  = $clog2(TO_CYC);
   localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
   localparam logic [TO_W-1:0]  WD_MAX   = TO_W'(TO_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC);

   arb_state_t r_state, w_state_nxt;

   logic [NUM_REQ-1:0]   r_pend;
   logic [SPI_CMD_W-1:0] r_cmd_q [NUM_REQ];
   logic [IDX_W-1:0]     r_rr_ptr;
   logic [IDX_W-1:0]     r_winner;
   logic [SPI_CMD_W-1:0] r_spi_cmd;
   logic [SPI_CMD_W-1:0] r_rsp_data;
   logic [NUM_REQ-1:0]   r_req_done;
   logic                 r_err_to;
   logic [TO_W-1:0]      r_wd_cnt;
   logic [GAP_W-1:0]     r_gap_cnt;

   logic                 w_any;
   logic [IDX_W-1:0]     w_winner;
   logic                 w_grant;
   logic                 w_fin_ok;
   logic                 w_fin_to;
   logic                 w_fin;
   logic [NUM_REQ-1:0]   w_win_oh;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_pend   (r_pend),
      .i_rr_ptr (r_rr_ptr),
      .o_any    (w_any),
      .o_winner (w_winner)
   );

   assign w_fin    = w_fin_ok | w_fin_to;
   assign w_win_oh = NUM_REQ'(1) << r_winner;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // spi_done takes priority over a watchdog expiry landing on the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_fin_ok    = 1'b0;
      w_fin_to    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_grant     = 1'b1;
               w_state_nxt = LAUNCH;
            end
         end
         LAUNCH: w_state_nxt = BUSY;
         BUSY: begin
            if (spi_done) begin
               w_fin_ok    = 1'b1;
               w_state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
            end else if (r_wd_cnt == WD_MAX) begin
               w_fin_to    = 1'b1;
               w_state_nxt = GAP;
            end
         end
         GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend     <= '0;
         r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
         r_winner   <= '0;
         r_spi_cmd  <= '0;
         r_rsp_data <= '0;
         r_req_done <= '0;
         r_err_to   <= 1'b0;
         r_wd_cnt   <= '0;
         r_gap_cnt  <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_cmd_q[i] <= '0;
         end
      end else begin
         r_req_done <= '0;
         // A request already pending is dropped; completion frees the slot for re-arm.
         r_pend <= (r_pend & ~(w_fin ? w_win_oh : '0)) | (req & ~r_pend);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !r_pend[i]) begin
               r_cmd_q[i] <= cmd_in[i*SPI_CMD_W +: SPI_CMD_W];
            end
         end

         if (w_grant) begin
            r_winner  <= w_winner;
            r_rr_ptr  <= w_winner;
            r_spi_cmd <= r_cmd_q[w_winner];
         end

         if (r_state == LAUNCH) begin
            r_wd_cnt <= '0;
         end else if (r_state == BUSY && r_wd_cnt != WD_MAX) begin
            r_wd_cnt <= r_wd_cnt + TO_W'(1);
         end

         if (w_fin_ok) begin
            r_rsp_data <= spi_rd_data;
         end
         if (w_fin_to) begin
            r_rsp_data <= TO_RSP;
            r_err_to   <= 1'b1;
         end

         if (w_fin) begin
            r_req_done <= w_win_oh;
            r_gap_cnt  <= '0;
         end else if (r_state == GAP && r_gap_cnt != GAP_LAST) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
         end
      end
   end

   assign req_done = r_req_done;
   assign rsp_data = r_rsp_data;
   assign busy     = (r_state != IDLE);
   assign err_to   = r_err_to;
   assign spi_wrt  = (r_state == LAUNCH);
   assign spi_cmd  = r_spi_cmd;

endmodule
`default_nettype wire

// File: tb/tb_spi_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_arb : table-driven and scoreboard bench for spi_arb
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_arb;

   localparam int N   = 3;
   localparam int GAP = 4;
   localparam int TO  = 1024;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req = '0;
   logic [16*N-1:0] cmd_in = '0;
   logic [N-1:0]    req_done;
   logic [15:0]     rsp_data;
   logic            busy;
   logic            err_to;
   logic            spi_wrt;
   logic [15:0]     spi_cmd;
   logic            spi_done = 1'b0;
   logic [15:0]     spi_rd_data = '0;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   spi_arb #(
      .NUM_REQ (N),
      .GAP_CYC (GAP),
      .TO_CYC  (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .cmd_in      (cmd_in),
      .req_done    (req_done),
      .rsp_data    (rsp_data),
      .busy        (busy),
      .err_to      (err_to),
      .spi_wrt     (spi_wrt),
      .spi_cmd     (spi_cmd),
      .spi_done    (spi_done),
      .spi_rd_data (spi_rd_data)
   );

   typedef struct packed {
      logic [1:0]  idx;
      logic [15:0] rsp;
   } done_t;

   typedef struct {
      logic [2:0]       mask;
      logic [2:0][15:0] cmd;
      logic [15:0]      xr;
      int               dly;
      int               n;
      logic [2:0][1:0]  ord;
   } vec_t;

   logic [15:0] q_l[$];
   done_t       q_d[$];
   vec_t        tbl[7];

   int n_cmp = 0;
   int n_bad = 0;
   int n_launch = 0;
   int launch_base = 0;
   int req_cyc = 0;
   int done_cyc = 0;
   int launch_cyc = 0;
   int rd_cyc = 0;
   bit chk_t = 1'b0;
   bit m_hold = 1'b0;
   int m_delay = 1;
   int m_cnt = 0;
   logic [15:0] m_xor = '0;
   logic [15:0] m_rd = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic flag(input string nm, input logic [31:0] act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0h expected nothing (cycle %0d)", nm, act, cyc);
   endtask

   task automatic push(input logic [1:0] idx, input logic [15:0] cmd);
      q_l.push_back(cmd);
      q_d.push_back({idx, cmd ^ m_xor});
   endtask

   task automatic pulse(input logic [N-1:0] m, input logic [16*N-1:0] c);
      cmd_in  = c;
      req     = m;
      req_cyc = cyc;
      @(negedge clk);
      req = '0;
   endtask

   task automatic wait_empty(input int bound, input string nm);
      int i = 0;
      while ((q_l.size() != 0 || q_d.size() != 0) && i < bound) begin
         @(negedge clk);
         i++;
      end
      if (q_l.size() != 0 || q_d.size() != 0) begin
         flag(nm, q_l.size() + q_d.size());
         q_l.delete();
         q_d.delete();
      end
   endtask

   // SPI master model: answers spi_cmd ^ m_xor m_delay cycles after spi_wrt.
   task automatic master();
      forever begin
         @(negedge clk);
         spi_done = 1'b0;
         if (rst) begin
            m_cnt = 0;
         end else if (spi_wrt) begin
            m_cnt = m_delay;
            m_rd  = spi_cmd ^ m_xor;
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && !m_hold) begin
               spi_done    = 1'b1;
               spi_rd_data = m_rd;
               done_cyc    = cyc;
            end
         end
      end
   endtask

   task automatic monitor();
      done_t d;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (spi_wrt) begin
               if (q_l.size() == 0) flag("unexpected_launch", spi_cmd);
               else chk("launch_cmd", spi_cmd, q_l.pop_front());
               if (chk_t) begin
                  if (n_launch == launch_base) chk("req_to_wrt", cyc - req_cyc, 2);
                  else chk("done_to_wrt", cyc - done_cyc, GAP + 3);
               end
               n_launch++;
               launch_cyc = cyc;
            end
            if (req_done != '0) begin
               rd_cyc = cyc;
               chk("done_onehot", $countones(req_done), 1);
               if (q_d.size() == 0) begin
                  flag("unexpected_req_done", req_done);
               end else begin
                  d = q_d.pop_front();
                  chk("done_idx", req_done, 32'(1) << d.idx);
                  chk("rsp_data", rsp_data, d.rsp);
               end
               if (chk_t) chk("spidone_to_reqdone", cyc - done_cyc, 1);
            end
         end
      end
   endtask

   initial begin
      int t;
      int base;
      tbl[0] = '{3'b111, {16'h2800, 16'h2000, 16'h0000}, 16'h5A5A, 10, 3, {2'd2, 2'd1, 2'd0}};
      tbl[1] = '{3'b001, {16'h0000, 16'h0000, 16'h0000}, 16'h0ABC, 40, 1, {2'd0, 2'd0, 2'd0}};
      tbl[2] = '{3'b110, {16'h2222, 16'h1111, 16'h0000}, 16'h0F0F,  5, 2, {2'd0, 2'd2, 2'd1}};
      tbl[3] = '{3'b101, {16'h4444, 16'h0000, 16'h3333}, 16'h1234,  7, 2, {2'd0, 2'd2, 2'd0}};
      tbl[4] = '{3'b011, {16'h0000, 16'h6666, 16'h5555}, 16'h00FF,  3, 2, {2'd0, 2'd1, 2'd0}};
      tbl[5] = '{3'b101, {16'h8888, 16'h0000, 16'h7777}, 16'hF00F, 12, 2, {2'd0, 2'd0, 2'd2}};
      tbl[6] = '{3'b110, {16'hAAAA, 16'h9999, 16'h0000}, 16'h3C3C,  1, 2, {2'd0, 2'd2, 2'd1}};

      fork
         monitor();
         master();
      join_none

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_req_done", req_done, 0);
      chk("rst_rsp_data", rsp_data, 16'h0000);
      chk("rst_err_to", err_to, 0);
      chk("rst_spi_wrt", spi_wrt, 0);
      chk("rst_spi_cmd", spi_cmd, 16'h0000);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         m_delay     = tbl[v].dly;
         m_xor       = tbl[v].xr;
         chk_t       = 1'b1;
         launch_base = n_launch;
         for (int k = 0; k < tbl[v].n; k++) begin
            push(tbl[v].ord[k], tbl[v].cmd[tbl[v].ord[k]]);
         end
         pulse(tbl[v].mask, tbl[v].cmd);
         wait_empty(600, "vec_timeout");
         repeat (8) @(negedge clk);
      end

      // Requester 0 re-requests on its own req_done while 1 is pending.
      m_delay = 20; m_xor = 16'h0101; chk_t = 1'b1; launch_base = n_launch;
      push(2'd0, 16'hA0A0); push(2'd1, 16'hB1B1); push(2'd0, 16'hA0A1);
      pulse(3'b001, {32'h0, 16'hA0A0});
      repeat (2) @(negedge clk);
      pulse(3'b010, {16'h0, 16'hB1B1, 16'h0});
      t = 0;
      while (!req_done[0] && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!req_done[0]) flag("fair_wait_timeout", t);
      pulse(3'b001, {32'h0, 16'hA0A1});
      wait_empty(300, "fair_timeout");
      repeat (8) @(negedge clk);

      // Duplicate pulse on req[2] while it waits behind a long frame.
      m_delay = 30; m_xor = 16'h00F0; chk_t = 1'b0; base = n_launch;
      push(2'd0, 16'h0D0D); push(2'd2, 16'hC0DE);
      pulse(3'b001, {32'h0, 16'h0D0D});
      repeat (3) @(negedge clk);
      pulse(3'b100, {16'hC0DE, 32'h0});
      repeat (2) @(negedge clk);
      pulse(3'b100, {16'h1234, 32'h0});
      wait_empty(300, "dup_timeout");
      repeat (20) @(negedge clk);
      chk("dup_launch_count", n_launch - base, 2);

      // Watchdog abort.
      m_hold = 1'b1; chk_t = 1'b0;
      q_l.push_back(16'h0BAD);
      q_d.push_back({2'd1, 16'hFFFF});
      pulse(3'b010, {16'h0, 16'h0BAD, 16'h0});
      wait_empty(TO + 100, "wd_timeout");
      chk("wd_latency", rd_cyc - launch_cyc, TO + 1);
      chk("err_to_set", err_to, 1);
      repeat (10) @(negedge clk);
      chk("err_to_sticky", err_to, 1);
      chk("wd_rsp_hold", rsp_data, 16'hFFFF);
      m_hold = 1'b0; m_delay = 4; m_xor = 16'h1111; chk_t = 1'b1; launch_base = n_launch;
      push(2'd2, 16'h2468);
      pulse(3'b100, {16'h2468, 32'h0});
      wait_empty(200, "post_wd_timeout");
      chk("err_to_after_ok", err_to, 1);
      repeat (8) @(negedge clk);

      // Reset in the middle of a frame.
      m_delay = 50; m_xor = '0; chk_t = 1'b0;
      q_l.push_back(16'hDEAD);
      pulse(3'b001, {32'h0, 16'hDEAD});
      repeat (8) @(negedge clk);
      chk("busy_pre_rst", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_req_done", req_done, 0);
      chk("rst_mid_err_to", err_to, 0);
      chk("rst_mid_launch_seen", q_l.size(), 0);
      q_l.delete();
      @(negedge clk);
      m_delay = 6; m_xor = 16'h0F0F; chk_t = 1'b1; launch_base = n_launch;
      push(2'd1, 16'h1357);
      pulse(3'b010, {16'h0, 16'h1357, 16'h0});
      wait_empty(200, "post_rst_timeout");
      repeat (60) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "bench time limit reached");
   end

endmodule
`default_nettype wire

// File: doc/spi_arb.md
Name: spi_arb

Overview:
- Arbiter/sequencer that shares one 16-bit SPI master among NUM_REQ requesters (A2D channel reader, inertial sensor interface, spare).
- Latches each requester's 16-bit command and issues it to the master.
- Waits for the master's completion and returns read data to the winner.
- Enforces a minimum idle gap between frames and a watchdog on stuck transactions.

Parameters:
- NUM_REQ, 3, number of requesters (2..4)
- GAP_CYC, 4, idle clk cycles forced between end of one frame and next launch (0 allowed)
- TO_CYC, 1024, max clk cycles in BUSY before watchdog abort

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_REQ  per-requester one-cycle request pulse
- cmd_in  in  16*NUM_REQ  per-requester command; slice i = bits [16*i+15:16*i], sampled on req[i]
- req_done  out  NUM_REQ  one-cycle completion pulse to winner
- rsp_data  out  16  read data of last completed frame, valid from req_done onward
- busy  out  1  high in any state other than IDLE
- err_to  out  1  sticky watchdog flag, cleared only by rst
- spi_wrt  out  1  start pulse to SPI master
- spi_cmd  out  16  command to SPI master
- spi_done  in  1  SPI master completion pulse
- spi_rd_data  in  16  SPI master read data

Behaviour:
- Single clock domain. All registers reset synchronously when rst=1 at a clk edge.
- Reset values:
  - req_done=0, rsp_data=16'h0000, busy=0, err_to=0, spi_wrt=0, spi_cmd=16'h0000.
  - pend=0, rr_ptr=NUM_REQ-1, state=IDLE.
- Request capture:
  - req[i]=1 with pend[i]=0: set pend[i], latch cmd_in slice into cmd_q[i].
  - req[i]=1 with pend[i]=1: ignored; cmd_q[i] is unchanged.
  - req[i]=1 in the same cycle req_done[i] pulses: re-arms pend[i] with the new cmd.
- Round-robin pick: search from rr_ptr+1 upward, wrapping at NUM_REQ. The first pend[i]=1 wins. After reset, requester 0 has highest priority.
- FSM:
  - IDLE: if any pend, record the winner index, drive spi_cmd=cmd_q[winner], set rr_ptr=winner, go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: spi_wrt=1 for exactly this cycle, clear the watchdog counter, go to BUSY. spi_cmd is held stable through BUSY.
  - BUSY: on spi_done=1:
    - rsp_data <= spi_rd_data.
    - req_done[winner] pulses on the next cycle (registered).
    - pend[winner] is cleared.
    - Go to GAP if GAP_CYC>0, else IDLE.
  - BUSY watchdog: if the counter reaches TO_CYC-1 without spi_done:
    - err_to <= 1, rsp_data <= 16'hFFFF.
    - req_done[winner] pulses, pend[winner] is cleared.
    - Go to GAP.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- Latency:
  - Uncontended request: req cycle N → spi_wrt at cycle N+2.
  - req_done is asserted one cycle after spi_done.
  - Back-to-back frames: next spi_wrt = spi_done cycle + GAP_CYC + 3.
- spi_done outside BUSY is ignored.
- At most one req_done bit is high in any cycle. spi_wrt is never high outside LAUNCH.
- rst mid-frame: the arbiter returns to IDLE, clears pend, and no req_done is issued. The SPI master shares the same rst.
- Counters:
  - Watchdog counter width is $clog2(TO_CYC) and saturates; it never wraps.
  - GAP counter width is $clog2(GAP_CYC+1).

Decomposition:
- Shared package spi_arb_pkg:
  - State typedef arb_state_t {IDLE, LAUNCH, BUSY, GAP}.
  - Constant SPI_CMD_W=16.
  - Constant TO_RSP=16'hFFFF.
- Sub-module rr_pick (combinational round-robin priority encoder):
  - Inputs: pend, rr_ptr.
  - Outputs: any, winner index.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single request: req[0] with cmd 16'h0000, master returns 16'h0ABC after 40 cycles.
  → spi_wrt 2 cycles after req with spi_cmd=16'h0000; req_done=3'b001 one cycle after spi_done; rsp_data=16'h0ABC.
- Simultaneous req[0], req[1], req[2] with cmds 16'h0000/16'h2000/16'h2800.
  → grants in order 0,1,2; each spi_wrt separated from the prior spi_done by GAP_CYC+3=7 cycles.
- Fairness: requester 0 re-requests in the same cycle as its req_done while req[1] is pending.
  → requester 1 is served before requester 0's second frame.
- Duplicate pulse: req[2] pulsed twice while pending, second time with cmd 16'h1234.
  → exactly one frame issued, with the first cmd; exactly one req_done[2].
- Watchdog: spi_done withheld.
  → after TO_CYC=1024 BUSY cycles, err_to=1 stays high, rsp_data=16'hFFFF, and req_done pulses for the winner; a following request completes normally.
- Reset mid-BUSY: rst asserted for 1 cycle during BUSY.
  → next cycle busy=0 and pend=0; no req_done; a subsequent req[1] is served first.
